// File: rtl/bit_packer_pkg.sv
// Shared constants for the bit packer: default word geometry and the output FIFO depth.
package bit_packer_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LENW   = 4;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bit_packer_sync_fifo2.sv
// Two-entry register FIFO carrying {len, word} records from the packer to the consumer.
// A push while full is accepted only when a pop frees a slot on the same edge.
module sync_fifo2
    import bit_packer_pkg::*;
#(
    parameter int DW = DEF_WIDTH + DEF_LENW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (count_q == 2'(FIFO_DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign head_o  = mem_q[rd_q];

    // Occupancy follows the accepted push and pop of this cycle.
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; reset empties the FIFO and zeroes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (rd_en) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bit_packer.sv
// Packs qualified serial bits LSB-first into WIDTH-bit words, with flush of partial
// words, a registered push into a 2-entry FIFO, and a sticky overflow flag.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic [LENW-1:0]  word_len,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int DW = WIDTH + LENW;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic             push_q, push_d;
    logic [DW-1:0]    push_data_q, push_data_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] shift_cap;
    logic [WIDTH-1:0] word_masked;
    logic [LENW-1:0]  cnt_cap;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_head;
    logic             pop;

    assign word_valid = ~fifo_empty;
    assign pop        = word_valid & word_ready;
    assign word_out   = fifo_head[WIDTH-1:0];
    assign word_len   = fifo_head[DW-1:WIDTH];
    assign overflow   = overflow_q;
    assign busy       = (cnt_q != '0) | word_valid;

    // Capture the incoming bit first, then decide whether a completed or flushed word is pushed.
    always_comb begin
        shift_cap   = shift_q;
        cnt_cap     = cnt_q;
        word_masked = '0;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (bit_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == LENW'(i)) begin
                    shift_cap[i] = bit_in;
                end
            end
            cnt_cap = cnt_q + LENW'(1);
        end
        // Only the bits actually received survive; upper positions read as zero.
        for (int i = 0; i < WIDTH; i++) begin
            if (LENW'(i) < cnt_cap) begin
                word_masked[i] = shift_cap[i];
            end
        end
        if ((cnt_cap == LENW'(WIDTH)) || (flush && (cnt_cap != '0))) begin
            push_d      = 1'b1;
            push_data_d = {cnt_cap, word_masked};
            shift_d     = '0;
            cnt_d       = '0;
        end else begin
            shift_d = shift_cap;
            cnt_d   = cnt_cap;
        end
    end

    // A push that finds the FIFO full with no pop on the same edge is lost and latched as overflow.
    always_comb begin
        overflow_d = overflow_q | (push_q & fifo_full & ~pop);
    end

    // Packer state, the registered push stage and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push_q),
        .data_i (push_data_q),
        .pop_i  (pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer (WIDTH=8, LENW=4): capture, flush, backpressure,
// overflow, concurrent push/pop when full, bit+flush together, and mid-operation reset.
module tb_bit_packer;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       flush;
    logic [7:0] word_out;
    logic [3:0] word_len;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;
    logic       busy;

    int n_cmp;
    int n_bad;

    bit_packer #(
        .WIDTH(8),
        .LENW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .flush     (flush),
        .word_out  (word_out),
        .word_len  (word_len),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n bits of w, LSB first, one per cycle with bit_valid=1.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in    = w[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", word_valid); end
        n_cmp++; if (word_out !== 8'h00) begin n_bad++; $display("FAIL reset_word got=%h want=00", word_out); end
        n_cmp++; if (word_len !== 4'd0) begin n_bad++; $display("FAIL reset_len got=%0d want=0", word_len); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_full_word();
        do_reset();
        word_ready = 1'b1;
        send_bits(8'h4D, 3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_partial got=%b want=1", busy); end
        send_bits(8'h4D >> 3, 5);
        // Completing edge just passed: the word sits in the push register, not yet visible.
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_early got=%b want=0", word_valid); end
        tick();
        n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b want=1", word_valid); end
        n_cmp++; if (word_out !== 8'h4D) begin n_bad++; $display("FAIL full_word got=%h want=4d", word_out); end
        n_cmp++; if (word_len !== 4'd8) begin n_bad++; $display("FAIL full_len got=%0d want=8", word_len); end
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_one_cycle got=%b want=0", word_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        word_ready = 1'b1;
        send_bits(8'b0000_0011, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // cnt is back to 0 and the word has not reached the FIFO yet.
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_cnt_cleared busy=%b want=0", busy); end
        tick();
        n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid got=%b want=1", word_valid); end
        n_cmp++; if (word_out !== 8'h03) begin n_bad++; $display("FAIL flush_word got=%h want=03", word_out); end
        n_cmp++; if (word_len !== 4'd3) begin n_bad++; $display("FAIL flush_len got=%0d want=3", word_len); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty_noop got=%b want=0", word_valid); end
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty_noop2 got=%b want=0", word_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        word_ready = 1'b0;
        send_bits(8'hAA, 8);
        send_bits(8'h55, 8);
        send_bits(8'hFF, 8);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        n_cmp++; if (word_out !== 8'hAA) begin n_bad++; $display("FAIL ovf_head0 got=%h want=aa", word_out); end
        word_ready = 1'b1;
        tick();
        n_cmp++; if (word_out !== 8'h55 || word_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_head1 got=%h/%b want=55/1", word_out, word_valid); end
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_ff_dropped valid=%b want=0", word_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        word_ready = 1'b0;
        send_bits(8'hAA, 8);
        send_bits(8'h55, 8);
        tick();
        send_bits(8'h3C, 8);
        // The completed word reaches the FIFO on the next edge; pop on that same edge.
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL pp_ovf got=%b want=0", overflow); end
        n_cmp++; if (word_out !== 8'h55) begin n_bad++; $display("FAIL pp_head0 got=%h want=55", word_out); end
        word_ready = 1'b1;
        tick();
        n_cmp++; if (word_out !== 8'h3C || word_len !== 4'd8) begin n_bad++; $display("FAIL pp_kept got=%h/%0d want=3c/8", word_out, word_len); end
        tick();
        n_cmp++; if (word_valid !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL pp_drain got=%b/%b want=0/0", word_valid, overflow); end
    endtask

    task automatic test_bit_and_flush();
        do_reset();
        word_ready = 1'b1;
        send_bits(8'hB5, 7);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        flush     = 1'b1;
        tick();
        bit_valid = 1'b0;
        flush     = 1'b0;
        bit_in    = 1'b0;
        tick();
        n_cmp++; if (word_out !== 8'hB5 || word_len !== 4'd8 || word_valid !== 1'b1) begin n_bad++; $display("FAIL bf_full got=%h/%0d/%b want=b5/8/1", word_out, word_len, word_valid); end
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL bf_single got=%b want=0", word_valid); end
        send_bits(8'b0000_0001, 2);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        flush     = 1'b1;
        tick();
        bit_valid = 1'b0;
        flush     = 1'b0;
        bit_in    = 1'b0;
        tick();
        n_cmp++; if (word_out !== 8'h05 || word_len !== 4'd3) begin n_bad++; $display("FAIL bf_partial got=%h/%0d want=05/3", word_out, word_len); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        word_ready = 1'b0;
        send_bits(8'hAA, 8);
        send_bits(8'h1F, 5);
        n_cmp++; if (word_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rm_pre got=%b/%b want=1/1", word_valid, busy); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({word_valid, word_out, word_len, overflow, busy} !== 15'd0) begin n_bad++; $display("FAIL rm_async got=%b/%h/%0d/%b/%b want=0", word_valid, word_out, word_len, overflow, busy); end
        tick();
        rst_n      = 1'b1;
        word_ready = 1'b1;
        tick();
        send_bits(8'h96, 8);
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_old got=%b want=0", word_valid); end
        tick();
        n_cmp++; if (word_out !== 8'h96 || word_len !== 4'd8 || word_valid !== 1'b1) begin n_bad++; $display("FAIL rm_new got=%h/%0d/%b want=96/8/1", word_out, word_len, word_valid); end
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rm_only_new got=%b want=0", word_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_push_pop_full();
        test_bit_and_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
